// File: rtl/hazard_unit_p_pkg.sv
// Shared constants and types for the MIPS pipeline hazard/forwarding unit.
// Stage indices follow the stg_en/stg_rst bit order {WB,MEM,EXE,ID,IF}.
package mips_hazard_pkg;

  localparam int STG_IF      = 0;
  localparam int STG_ID      = 1;
  localparam int STG_EXE     = 2;
  localparam int STG_MEM     = 3;
  localparam int STG_WB      = 4;
  localparam int NUM_CTL_STG = 5;
  localparam int SEL_NONE    = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } irq_state_t;

  // Register $0 is hard-wired to zero, so a write to it is never a producer.
  function automatic logic addr_hit(input logic wen, input logic [4:0] waddr,
                                    input logic [4:0] addr);
    return wen && (waddr != 5'd0) && (waddr == addr);
  endfunction

endpackage

// File: rtl/hazard_unit_p_if.sv
// Bundle between the ID-stage pipeline control and the hazard unit.
// master = pipeline side driving operand/stage info, slave = hazard unit.
interface hazard_unit_p_if #(
  parameter int NUM_STG = 3,
  parameter int SEL_W   = $clog2(NUM_STG + 1)
);
  logic                   rs_used;
  logic                   rt_used;
  logic [4:0]             addr_rs;
  logic [4:0]             addr_rt;
  logic                   is_store_id;
  logic [NUM_STG-1:0]     wen_stg;
  logic [5*NUM_STG-1:0]   waddr_stg;
  logic [NUM_STG-1:0]     is_load_stg;
  logic                   jump_en;
  logic                   eret_id;
  logic                   irq_req;
  logic                   mem_busy;
  logic                   debug_en;
  logic                   debug_step;
  logic [SEL_W-1:0]       fwd_a;
  logic [SEL_W-1:0]       fwd_b;
  logic                   fwd_m;
  logic [4:0]             stg_en;
  logic [4:0]             stg_rst;
  logic                   ir_en;
  logic                   irq_take;

  modport master (
    output rs_used, rt_used, addr_rs, addr_rt, is_store_id,
    output wen_stg, waddr_stg, is_load_stg,
    output jump_en, eret_id, irq_req, mem_busy, debug_en, debug_step,
    input  fwd_a, fwd_b, fwd_m, stg_en, stg_rst, ir_en, irq_take
  );

  modport slave (
    input  rs_used, rt_used, addr_rs, addr_rt, is_store_id,
    input  wen_stg, waddr_stg, is_load_stg,
    input  jump_en, eret_id, irq_req, mem_busy, debug_en, debug_step,
    output fwd_a, fwd_b, fwd_m, stg_en, stg_rst, ir_en, irq_take
  );

endinterface

// File: rtl/hazard_unit_p_fwd_match.sv
// Priority match of one source register against all in-flight producers;
// the youngest (lowest-index) matching stage wins.
module fwd_match
  import mips_hazard_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic                 used,
  input  logic [4:0]           addr,
  input  logic [NUM_STG-1:0]   wen_stg,
  input  logic [5*NUM_STG-1:0] waddr_stg,
  input  logic [NUM_STG-1:0]   is_load_stg,
  output logic [SEL_W-1:0]     sel,
  output logic                 is_load_hit
);

  logic [NUM_STG-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STG; gi++) begin : g_hit
      assign hit[gi] = used & addr_hit(wen_stg[gi], waddr_stg[5*gi +: 5], addr);
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit overwrites.
  always_comb begin
    sel         = SEL_W'(SEL_NONE);
    is_load_hit = 1'b0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel         = SEL_W'(k + 1);
        is_load_hit = is_load_stg[k];
      end
    end
  end

endmodule

// File: rtl/hazard_unit_p.sv
// Pipeline hazard/forwarding unit: operand forwarding, load-use stall,
// branch flush, memory freeze, debug single-step and interrupt entry/exit.
module hazard_unit_p
  import mips_hazard_pkg::*;
#(
  parameter int NUM_STG      = 3,
  parameter int LOAD_RDY_STG = 1,
  parameter int FLUSH_SLOTS  = 1,
  parameter int SEL_W        = $clog2(NUM_STG + 1)
) (
  input  logic           clk,
  input  logic           rst,
  hazard_unit_p_if.slave hz
);

  logic [SEL_W-1:0]       sel_a, sel_b;
  logic                   load_a, load_b;
  logic                   stall_a, stall_b, store_fwd, load_stall;
  logic                   step_edge, frozen, advance;
  logic [NUM_CTL_STG-1:0] stg_en_c, stg_rst_c;

  irq_state_t irq_state_q, irq_state_d;
  logic       ir_en_q, ir_en_d;
  logic       irq_take_q, irq_take_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       step_prev_q, step_prev_d;

  fwd_match #(.NUM_STG(NUM_STG), .SEL_W(SEL_W)) u_match_rs (
    .used        (hz.rs_used),
    .addr        (hz.addr_rs),
    .wen_stg     (hz.wen_stg),
    .waddr_stg   (hz.waddr_stg),
    .is_load_stg (hz.is_load_stg),
    .sel         (sel_a),
    .is_load_hit (load_a)
  );

  fwd_match #(.NUM_STG(NUM_STG), .SEL_W(SEL_W)) u_match_rt (
    .used        (hz.rt_used),
    .addr        (hz.addr_rt),
    .wen_stg     (hz.wen_stg),
    .waddr_stg   (hz.waddr_stg),
    .is_load_stg (hz.is_load_stg),
    .sel         (sel_b),
    .is_load_hit (load_b)
  );

  // A store only needs rt in MEM, so a load one stage ahead can hand its
  // data straight across instead of stalling.
  always_comb begin
    stall_a    = load_a && (int'(sel_a) <= LOAD_RDY_STG);
    stall_b    = load_b && (int'(sel_b) <= LOAD_RDY_STG);
    store_fwd  = hz.is_store_id && stall_b && (sel_b == SEL_W'(1)) && !stall_a;
    load_stall = stall_a || (stall_b && !store_fwd);
  end

  assign hz.fwd_a = sel_a;
  assign hz.fwd_b = store_fwd ? SEL_W'(SEL_NONE) : sel_b;
  assign hz.fwd_m = store_fwd;

  always_comb begin
    step_edge = hz.debug_step && !step_prev_q;
    frozen    = (hz.debug_en && !step_edge) || hz.mem_busy;
    advance   = !frozen && !load_stall;
  end

  always_comb begin
    stg_en_c  = '1;
    stg_rst_c = '0;
    if (rst) begin
      stg_en_c  = '1;
      stg_rst_c = '1;
    end else if (frozen) begin
      stg_en_c  = '0;
    end else if (load_stall) begin
      stg_en_c[STG_IF]   = 1'b0;
      stg_en_c[STG_ID]   = 1'b0;
      stg_rst_c[STG_EXE] = 1'b1;
    end else if ((flush_cnt_q != 3'd0) || hz.jump_en) begin
      stg_rst_c[STG_ID]  = 1'b1;
    end
  end

  assign hz.stg_en   = stg_en_c;
  assign hz.stg_rst  = stg_rst_c;
  assign hz.ir_en    = ir_en_q;
  assign hz.irq_take = irq_take_q;

  // The jump cycle itself squashes ID, so the counter covers the remaining slots.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (!frozen) begin
      if (hz.jump_en)
        flush_cnt_d = 3'(FLUSH_SLOTS - 1);
      else if (flush_cnt_q != 3'd0)
        flush_cnt_d = flush_cnt_q - 3'd1;
    end
  end

  always_comb begin
    step_prev_d = hz.debug_step;
    irq_state_d = irq_state_q;
    ir_en_d     = ir_en_q;
    irq_take_d  = 1'b0;
    if (advance) begin
      case (irq_state_q)
        IDLE: begin
          // Never enter the handler on a redirect cycle; the jump target wins.
          if (hz.irq_req && ir_en_q && !hz.jump_en) begin
            irq_take_d  = 1'b1;
            ir_en_d     = 1'b0;
            irq_state_d = ACTIVE;
          end
        end
        ACTIVE: if (hz.eret_id) irq_state_d = DRAIN;
        DRAIN: begin
          ir_en_d     = 1'b1;
          irq_state_d = IDLE;
        end
        default: irq_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_state_q <= IDLE;
      ir_en_q     <= 1'b1;
      irq_take_q  <= 1'b0;
      flush_cnt_q <= 3'd0;
      step_prev_q <= 1'b0;
    end else begin
      irq_state_q <= irq_state_d;
      ir_en_q     <= ir_en_d;
      irq_take_q  <= irq_take_d;
      flush_cnt_q <= flush_cnt_d;
      step_prev_q <= step_prev_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed bench for hazard_unit_p: each cycle's stimulus queues its expected
// outputs, and an independent monitor compares them on the falling edge.
module tb_hazard_unit_p;

  localparam logic [4:0] ALL = 5'h1F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_p_if #(.NUM_STG(3)) hif();

  hazard_unit_p #(.NUM_STG(3), .LOAD_RDY_STG(1), .FLUSH_SLOTS(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fm;
    logic [4:0] en;
    logic [4:0] sr;
    logic       ie;
    logic       it;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
  } sb_t;

  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;
  sb_t  mon_s;
  exp_t mon_got;

  function automatic exp_t ex(int fa, int fb, int fm, int en, int sr, int ie, int it);
    exp_t e;
    e.fa = 2'(fa); e.fb = 2'(fb); e.fm = 1'(fm);
    e.en = 5'(en); e.sr = 5'(sr); e.ie = 1'(ie); e.it = 1'(it);
    return e;
  endfunction

  function automatic logic [14:0] wa(int a0, int a1, int a2);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic clr();
    rst              = 1'b0;
    hif.rs_used      = 1'b0;
    hif.rt_used      = 1'b0;
    hif.addr_rs      = 5'd0;
    hif.addr_rt      = 5'd0;
    hif.is_store_id  = 1'b0;
    hif.wen_stg      = 3'b000;
    hif.waddr_stg    = 15'd0;
    hif.is_load_stg  = 3'b000;
    hif.jump_en      = 1'b0;
    hif.eret_id      = 1'b0;
    hif.irq_req      = 1'b0;
    hif.mem_busy     = 1'b0;
    hif.debug_en     = 1'b0;
    hif.debug_step   = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic push(input string nm, input exp_t e);
    sb_t s;
    s.nm = nm;
    s.e  = e;
    sb_q.push_back(s);
  endtask

  task automatic ops(input int rs, input int rt, input logic [2:0] wen,
                     input logic [14:0] waddr, input logic [2:0] ld);
    hif.rs_used     = 1'b1;
    hif.rt_used     = 1'b1;
    hif.addr_rs     = 5'(rs);
    hif.addr_rt     = 5'(rt);
    hif.wen_stg     = wen;
    hif.waddr_stg   = waddr;
    hif.is_load_stg = ld;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_s   = sb_q.pop_front();
        mon_got = {hif.fwd_a, hif.fwd_b, hif.fwd_m, hif.stg_en, hif.stg_rst,
                   hif.ir_en, hif.irq_take};
        total++;
        if (mon_got !== mon_s.e) begin
          bad++;
          $display("FAIL %s: got fa=%0d fb=%0d fm=%b en=%b rst=%b ie=%b it=%b, want fa=%0d fb=%0d fm=%b en=%b rst=%b ie=%b it=%b",
                   mon_s.nm, mon_got.fa, mon_got.fb, mon_got.fm, mon_got.en, mon_got.sr,
                   mon_got.ie, mon_got.it, mon_s.e.fa, mon_s.e.fb, mon_s.e.fm, mon_s.e.en,
                   mon_s.e.sr, mon_s.e.ie, mon_s.e.it);
        end else begin
          $display("ok   %s: fa=%0d fb=%0d fm=%b en=%b rst=%b ie=%b it=%b",
                   mon_s.nm, mon_got.fa, mon_got.fb, mon_got.fm, mon_got.en, mon_got.sr,
                   mon_got.ie, mon_got.it);
        end
      end
    end
  end

  initial begin : stimulus
    clr();
    rst = 1'b1;

    next(); rst = 1'b1;                          push("reset",      ex(0,0,0,ALL,ALL,1,0));
    next();                                      push("idle",       ex(0,0,0,ALL,0,1,0));

    // Forwarding
    next(); ops(3,5,3'b001,wa(3,0,0),3'b000);    push("fwd_exe",    ex(1,0,0,ALL,0,1,0));
    next(); ops(3,5,3'b010,wa(0,3,0),3'b000);    push("fwd_mem",    ex(2,0,0,ALL,0,1,0));
    next(); ops(3,3,3'b011,wa(3,3,0),3'b000);    push("fwd_prio",   ex(1,1,0,ALL,0,1,0));
    next(); ops(0,0,3'b001,wa(0,0,0),3'b000);    push("zero_reg",   ex(0,0,0,ALL,0,1,0));
    next(); ops(1,7,3'b001,wa(7,0,0),3'b000);
            hif.rt_used = 1'b0;                  push("rt_unused",  ex(0,0,0,ALL,0,1,0));
    next(); ops(9,9,3'b100,wa(0,0,9),3'b000);    push("fwd_wb",     ex(3,3,0,ALL,0,1,0));

    // Load-use
    next(); ops(4,2,3'b001,wa(4,0,0),3'b001);    push("ld_stall",   ex(1,0,0,5'b11100,5'b00100,1,0));
    next(); ops(4,2,3'b010,wa(0,4,0),3'b010);    push("ld_mem",     ex(2,0,0,ALL,0,1,0));
    next(); ops(1,4,3'b001,wa(4,0,0),3'b001);
            hif.is_store_id = 1'b1;              push("sw_fwdm",    ex(0,0,1,ALL,0,1,0));
    next(); ops(4,6,3'b001,wa(4,0,0),3'b001);
            hif.is_store_id = 1'b1;              push("sw_addr",    ex(1,0,0,5'b11100,5'b00100,1,0));

    // Branch flush, three slots, with a memory freeze in the middle
    next(); hif.jump_en = 1'b1;                  push("jmp0",       ex(0,0,0,ALL,5'b00010,1,0));
    next();                                      push("jmp1",       ex(0,0,0,ALL,5'b00010,1,0));
    next(); hif.mem_busy = 1'b1;                 push("jmp_busy",   ex(0,0,0,0,0,1,0));
    next();                                      push("jmp2",       ex(0,0,0,ALL,5'b00010,1,0));
    next();                                      push("jmp_done",   ex(0,0,0,ALL,0,1,0));

    // Interrupt entry/exit, no nesting
    next(); hif.irq_req = 1'b1;                  push("irq_req",    ex(0,0,0,ALL,0,1,0));
    next(); hif.irq_req = 1'b1;                  push("irq_take",   ex(0,0,0,ALL,0,0,1));
    next(); hif.irq_req = 1'b1;                  push("irq_nest",   ex(0,0,0,ALL,0,0,0));
    next(); hif.irq_req = 1'b1; hif.eret_id = 1; push("eret",       ex(0,0,0,ALL,0,0,0));
    next(); hif.irq_req = 1'b1;                  push("drain",      ex(0,0,0,ALL,0,0,0));
    next();                                      push("irq_ien",    ex(0,0,0,ALL,0,1,0));

    // Interrupt coincident with jump is deferred one cycle
    next(); hif.irq_req = 1'b1; hif.jump_en = 1; push("irq_defer",  ex(0,0,0,ALL,5'b00010,1,0));
    next(); hif.irq_req = 1'b1;                  push("irq_defer2", ex(0,0,0,ALL,5'b00010,1,0));
    next();                                      push("irq_late",   ex(0,0,0,ALL,5'b00010,0,1));

    // Reset while inside the handler
    next(); rst = 1'b1;                          push("rst_isr",    ex(0,0,0,ALL,ALL,1,0));
    next();                                      push("post_rst",   ex(0,0,0,ALL,0,1,0));

    // Debug single-step: one enabled cycle per rising edge of debug_step
    next(); hif.debug_en = 1'b1;                 push("dbg_halt",   ex(0,0,0,0,0,1,0));
    next(); hif.debug_en = 1'b1; hif.debug_step = 1'b1;
                                                 push("dbg_step",   ex(0,0,0,ALL,0,1,0));
    for (int i = 0; i < 4; i++) begin
      next(); hif.debug_en = 1'b1; hif.debug_step = 1'b1;
                                                 push("dbg_hold",   ex(0,0,0,0,0,1,0));
    end
    next();                                      push("dbg_exit",   ex(0,0,0,ALL,0,1,0));

    // Freeze outranks a load stall
    next(); ops(4,2,3'b001,wa(4,0,0),3'b001);
            hif.mem_busy = 1'b1;                 push("busy_stall", ex(1,0,0,0,0,1,0));

    next();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
